timer_counter: RTL and testbench
================================

# timer_counter

Readout sequencer and per-state cycle timer for the pixel readout path. The block watches the 2-bit main controller state and, while it is READOUT, steps through a fixed sub-sequence: reset read (NRE), conversion (ADC), idle gap, second reset read, second conversion, end. Downstream logic (row/column drivers, ADC strobes) decodes the current sub-state and the cycle index within it from the two outputs.

## Interface
- D_NRE, default 2: cycles spent in each NRE state (legal 1..4).
- D_ADC, default 4: cycles spent in each ADC state (legal 1..4).
- D_NOTHING, default 1: cycles spent in the NOTHING gap (legal 1..4).
- i_Clock  in  1  single system clock, all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset; priority over every other input.
- i_Main_FSM  in  2  main controller state: 2'b00 IDLE, 2'b01 EXPOSURE, 2'b10 READOUT, 2'b11 reserved (treated as not READOUT).
- o_RD_FSM  out  3  readout sub-state: 000 INIT, 001 NRE_1, 010 ADC_1, 011 NOTHING, 100 NRE_2, 101 ADC_2, 110 END (111 never driven).
- o_RD_timer  out  2  cycle index within the current sub-state, 0-based.

## Operation
- Outputs are registered state and counter, driven directly (no combinational decode).
- INIT: waiting state, timer held 0. If i_Main_FSM == READOUT sampled, next state NRE_1.
- NRE_1 -> ADC_1 -> NOTHING -> NRE_2 -> ADC_2 -> END, each lasting its parameter duration D cycles; timer counts 0..D-1, then state advances and timer returns to 0 on the same edge.
- NRE_1/NRE_2 use D_NRE; ADC_1/ADC_2 use D_ADC; NOTHING uses D_NOTHING.
- END: timer held 0; stays in END while i_Main_FSM == READOUT; when i_Main_FSM != READOUT sampled, next state INIT. No automatic restart: a new sequence needs the main FSM to leave and re-enter READOUT.
- Abort: in any state other than INIT/END, if i_Main_FSM != READOUT is sampled, next state INIT, timer 0 (abort wins over a simultaneous timer expiry).
- Timer is 2 bits; with legal parameters it never wraps. Durations outside 1..4 are illegal (elaboration-time check).

## Timing
- Reset: on any rising edge with i_Reset=1, o_RD_FSM=000 (INIT), o_RD_timer=0 next cycle; reset mid-sequence abandons it.
- Start latency: READOUT sampled at edge k in INIT -> o_RD_FSM=NRE_1, timer 0 after edge k.
- With defaults, relative to edge k: NRE_1 t0,t1 (k, k+1); ADC_1 t0..t3 (k+2..k+5); NOTHING t0 (k+6); NRE_2 t0,t1 (k+7, k+8); ADC_2 t0..t3 (k+9..k+12); END from k+13. Total active sequence 13 cycles.
- Every transition and counter update happens on the rising edge; i_Main_FSM is sampled only on rising edges (assumed synchronous to i_Clock).

## Test plan
- Reset: hold i_Reset=1 for 2 cycles with i_Main_FSM=READOUT -> o_RD_FSM=000, o_RD_timer=0 throughout and one cycle after release only then NRE_1 starts.
- Full sequence: release reset, IDLE 2 cycles, then READOUT held -> exact default trace above (FSM 001,001,010x4,011,100,100,101x4,110...) with timer 0,1,0,1,2,3,0,0,1,0,1,2,3,0.
- Hold in END: keep READOUT 10 extra cycles -> o_RD_FSM stays 110, timer 0; drop to IDLE -> INIT next cycle; re-enter READOUT -> sequence repeats identically.
- Abort: switch i_Main_FSM to EXPOSURE during ADC_1 timer 2 -> next cycle INIT, timer 0; no further advance while not READOUT.
- Reset mid-operation: assert i_Reset during NRE_2 with READOUT held -> INIT/0 next cycle, restart NRE_1 the cycle after reset release.
- Parameters: D_NRE=1, D_ADC=3, D_NOTHING=4 -> NRE states 1 cycle (timer 0), ADC states timer 0..2, NOTHING timer 0..3; reserved input 2'b11 behaves as IDLE.

Source files
------------

// File: rtl/timer_counter.sv
// Readout sub-sequencer: steps NRE_1/ADC_1/NOTHING/NRE_2/ADC_2/END while the main FSM is READOUT.
// Latency: registered, first sub-state one edge after READOUT is sampled; no backpressure, abort returns to INIT.
module timer_counter #(
   parameter int D_NRE     = 2,
   parameter int D_ADC     = 4,
   parameter int D_NOTHING = 1
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic [1:0] i_Main_FSM,
   output logic [2:0] o_RD_FSM,
   output logic [1:0] o_RD_timer
);

   typedef enum logic [2:0] {
      S_INIT    = 3'd0,
      S_NRE_1   = 3'd1,
      S_ADC_1   = 3'd2,
      S_NOTHING = 3'd3,
      S_NRE_2   = 3'd4,
      S_ADC_2   = 3'd5,
      S_END     = 3'd6
   } rd_state_t;

   localparam logic [1:0] MAIN_READOUT = 2'b10;
   localparam logic [1:0] NRE_LAST     = 2'(D_NRE - 1);
   localparam logic [1:0] ADC_LAST     = 2'(D_ADC - 1);
   localparam logic [1:0] NOTHING_LAST = 2'(D_NOTHING - 1);

   // The 2-bit timer only covers durations 1..4.
   if (D_NRE < 1 || D_NRE > 4) begin : g_bad_nre
      $error("timer_counter: D_NRE must be in 1..4");
   end
   if (D_ADC < 1 || D_ADC > 4) begin : g_bad_adc
      $error("timer_counter: D_ADC must be in 1..4");
   end
   if (D_NOTHING < 1 || D_NOTHING > 4) begin : g_bad_nothing
      $error("timer_counter: D_NOTHING must be in 1..4");
   end

   rd_state_t  state;
   rd_state_t  adv_state;
   logic [1:0] timer;
   logic [1:0] last_cnt;
   logic       readout;

   assign readout = (i_Main_FSM == MAIN_READOUT);

   always_comb begin
      last_cnt  = 2'd0;
      adv_state = S_INIT;
      case (state)
         S_NRE_1:   begin last_cnt = NRE_LAST;     adv_state = S_ADC_1;   end
         S_ADC_1:   begin last_cnt = ADC_LAST;     adv_state = S_NOTHING; end
         S_NOTHING: begin last_cnt = NOTHING_LAST; adv_state = S_NRE_2;   end
         S_NRE_2:   begin last_cnt = NRE_LAST;     adv_state = S_ADC_2;   end
         S_ADC_2:   begin last_cnt = ADC_LAST;     adv_state = S_END;     end
         default:   begin last_cnt = 2'd0;         adv_state = S_INIT;    end
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state <= S_INIT;
         timer <= 2'd0;
      end else begin
         case (state)
            S_INIT: begin
               timer <= 2'd0;
               if (readout) state <= S_NRE_1;
            end
            S_END: begin
               timer <= 2'd0;
               if (!readout) state <= S_INIT;
            end
            default: begin
               // Leaving READOUT beats a timer expiry on the same edge.
               if (!readout) begin
                  state <= S_INIT;
                  timer <= 2'd0;
               end else if (timer == last_cnt) begin
                  state <= adv_state;
                  timer <= 2'd0;
               end else begin
                  timer <= timer + 2'd1;
               end
            end
         endcase
      end
   end

   assign o_RD_FSM   = state;
   assign o_RD_timer = timer;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: default parameters and a (1,3,4) variant.
module tb_timer_counter;

   localparam logic [1:0] M_IDLE = 2'b00;
   localparam logic [1:0] M_EXP  = 2'b01;
   localparam logic [1:0] M_RD   = 2'b10;
   localparam logic [1:0] M_RES  = 2'b11;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] main_a;
   logic [1:0] main_b;
   logic [2:0] fsm_a;
   logic [1:0] tmr_a;
   logic [2:0] fsm_b;
   logic [1:0] tmr_b;

   int compared   = 0;
   int mismatched = 0;

   // Default-parameter trace starting at the edge that samples READOUT in INIT.
   logic [2:0] trace_a_f [14] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3,
                                  3'd4, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5, 3'd6};
   logic [1:0] trace_a_t [14] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0,
                                  2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   // D_NRE=1, D_ADC=3, D_NOTHING=4 trace.
   logic [2:0] trace_b_f [13] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3,
                                  3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd6};
   logic [1:0] trace_b_t [13] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2,
                                  2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};

   always #5 clk = ~clk;

   timer_counter u_dut_a (
      .i_Clock    (clk),
      .i_Reset    (rst),
      .i_Main_FSM (main_a),
      .o_RD_FSM   (fsm_a),
      .o_RD_timer (tmr_a)
   );

   timer_counter #(.D_NRE(1), .D_ADC(3), .D_NOTHING(4)) u_dut_b (
      .i_Clock    (clk),
      .i_Reset    (rst),
      .i_Main_FSM (main_b),
      .o_RD_FSM   (fsm_b),
      .o_RD_timer (tmr_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [2:0] act_f, input logic [1:0] act_t,
                      input logic [2:0] exp_f, input logic [1:0] exp_t);
      compared++;
      assert ({act_f, act_t} === {exp_f, exp_t})
      else begin
         mismatched++;
         $error("FAIL %s: observed fsm=%0d timer=%0d expected fsm=%0d timer=%0d",
                tag, act_f, act_t, exp_f, exp_t);
      end
   endtask

   task automatic run_trace_a(input string tag);
      for (int i = 0; i < 14; i++) begin
         step();
         chk($sformatf("%s[%0d]", tag, i), fsm_a, tmr_a, trace_a_f[i], trace_a_t[i]);
      end
   endtask

   initial begin
      rst    = 1'b1;
      main_a = M_RD;
      main_b = M_IDLE;

      // Reset held two cycles with READOUT present.
      step(); chk("rst_0", fsm_a, tmr_a, 3'd0, 2'd0);
      step(); chk("rst_1", fsm_a, tmr_a, 3'd0, 2'd0);
      chk("rst_b", fsm_b, tmr_b, 3'd0, 2'd0);

      rst    = 1'b0;
      main_a = M_IDLE;
      step(); chk("idle_0", fsm_a, tmr_a, 3'd0, 2'd0);
      step(); chk("idle_1", fsm_a, tmr_a, 3'd0, 2'd0);

      main_a = M_RD;
      run_trace_a("seq1");

      for (int i = 0; i < 10; i++) begin
         step(); chk($sformatf("end_hold[%0d]", i), fsm_a, tmr_a, 3'd6, 2'd0);
      end

      main_a = M_IDLE;
      step(); chk("end_exit", fsm_a, tmr_a, 3'd0, 2'd0);

      main_a = M_RD;
      run_trace_a("seq2");

      // Abort during ADC_1 timer 2.
      main_a = M_IDLE;
      step(); chk("abort_pre", fsm_a, tmr_a, 3'd0, 2'd0);
      main_a = M_RD;
      for (int i = 0; i < 5; i++) begin
         step(); chk($sformatf("abort_run[%0d]", i), fsm_a, tmr_a, trace_a_f[i], trace_a_t[i]);
      end
      main_a = M_EXP;
      step(); chk("abort_init", fsm_a, tmr_a, 3'd0, 2'd0);
      for (int i = 0; i < 3; i++) begin
         step(); chk($sformatf("abort_stay[%0d]", i), fsm_a, tmr_a, 3'd0, 2'd0);
      end

      // Reset during NRE_2 with READOUT held.
      main_a = M_RD;
      for (int i = 0; i < 8; i++) begin
         step(); chk($sformatf("mid_run[%0d]", i), fsm_a, tmr_a, trace_a_f[i], trace_a_t[i]);
      end
      rst = 1'b1;
      step(); chk("mid_rst", fsm_a, tmr_a, 3'd0, 2'd0);
      rst = 1'b0;
      step(); chk("mid_restart0", fsm_a, tmr_a, 3'd1, 2'd0);
      step(); chk("mid_restart1", fsm_a, tmr_a, 3'd1, 2'd1);
      // Abort on the last NRE_1 cycle beats the expiry.
      main_a = M_IDLE;
      step(); chk("abort_vs_expiry", fsm_a, tmr_a, 3'd0, 2'd0);

      // Alternate parameter set.
      main_b = M_RD;
      for (int i = 0; i < 13; i++) begin
         step();
         chk($sformatf("par[%0d]", i), fsm_b, tmr_b, trace_b_f[i], trace_b_t[i]);
      end
      step(); chk("par_end_hold", fsm_b, tmr_b, 3'd6, 2'd0);

      // Reserved main state behaves as IDLE.
      main_b = M_RES;
      step(); chk("res_end_exit", fsm_b, tmr_b, 3'd0, 2'd0);
      step(); chk("res_init_stay", fsm_b, tmr_b, 3'd0, 2'd0);
      main_b = M_RD;
      step(); chk("res_start", fsm_b, tmr_b, 3'd1, 2'd0);
      step(); chk("res_adc", fsm_b, tmr_b, 3'd2, 2'd0);
      main_b = M_RES;
      step(); chk("res_abort", fsm_b, tmr_b, 3'd0, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
